dac_spi_tx: RTL and testbench

DAC_SPI_TX -- requirements
Module: dac_spi_tx

---
 rtl/dac_spi_tx.sv | 110 +++++++++++
 tb/tb_dac_spi_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises one 16-bit DAC word {2'b00, pd_mode, data_in}
// MSB first over a SYNC/SCLK/DIN three-wire link. SCLK idles high and the
// DAC samples DIN on SCLK falling edges. Frame period is 35*CLK_DIV clocks.
module dac_spi_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] data_in,
    input  logic [1:0]  pd_mode,
    input  logic        valid,
    output logic        ready,
    output logic        done,
    output logic        sync,
    output logic        sclk,
    output logic        sdin
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // Last count of one SCLK half-period.
    localparam logic [8:0] DIV_LAST  = 9'(CLK_DIV - 1);
    // HOLD ends one cycle early: ready rises on the last hold cycle so the
    // earliest next accept edge lands exactly 2*CLK_DIV clocks after sync rose.
    localparam logic [8:0] HOLD_LAST = 9'(2 * CLK_DIV - 2);

    logic [1:0]  state;
    logic [8:0]  div_cnt;
    logic [3:0]  bit_cnt;
    logic [14:0] shreg;      // remaining bits below the one currently on sdin
    logic [15:0] frame_in;

    assign frame_in = {2'b00, pd_mode, data_in};

    // Frame sequencer: every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            sync    <= 1'b1;
            sclk    <= 1'b1;
            sdin    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid && ready) begin
                        shreg   <= frame_in[14:0];
                        sdin    <= frame_in[15];
                        sync    <= 1'b0;
                        ready   <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= 4'd15;
                        state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    // sync low with sclk high for one half-period before bit 15
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        sclk    <= 1'b0;
                        state   <= S_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 9'd1;
                    end
                end
                S_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            // rising edge: DAC has sampled, present the next bit
                            sclk  <= 1'b1;
                            sdin  <= shreg[14];
                            shreg <= {shreg[13:0], 1'b0};
                        end else if (bit_cnt == 4'd0) begin
                            // all 16 bits clocked out: release the DAC
                            sync  <= 1'b1;
                            sdin  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_HOLD;
                        end else begin
                            sclk    <= 1'b0;
                            bit_cnt <= bit_cnt - 4'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 9'd1;
                    end
                end
                S_HOLD: begin
                    if (div_cnt == HOLD_LAST) begin
                        div_cnt <= '0;
                        ready   <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        div_cnt <= div_cnt + 9'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: two instances (CLK_DIV=4 and CLK_DIV=1) checked every
// cycle against a time-indexed model of the frame waveform, plus a DAC-side
// capture of the bits seen on SCLK falling edges and directed literal checks.
module tb_dac_spi_tx;

    localparam int D0 = 4;
    localparam int D1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid4;
    logic        valid1;
    logic [11:0] data_in;
    logic [1:0]  pd_mode;
    logic [1:0]  ready, done, sync, sclk, sdin;   // [0]=div4, [1]=div1

    dac_spi_tx #(.CLK_DIV(D0)) u_div4 (
        .clk(clk), .rst(rst), .data_in(data_in), .pd_mode(pd_mode), .valid(valid4),
        .ready(ready[0]), .done(done[0]), .sync(sync[0]), .sclk(sclk[0]), .sdin(sdin[0])
    );

    dac_spi_tx #(.CLK_DIV(D1)) u_div1 (
        .clk(clk), .rst(rst), .data_in(data_in), .pd_mode(pd_mode), .valid(valid1),
        .ready(ready[1]), .done(done[1]), .sync(sync[1]), .sclk(sclk[1]), .sdin(sdin[1])
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // model state: busy flag, clocks since accept, frame latched at accept
    bit          busy[2]   = '{1'b0, 1'b0};
    int          t[2]      = '{0, 0};
    logic [15:0] mframe[2] = '{16'h0, 16'h0};

    int acc_cyc[2]  = '{0, 0};
    int done_cyc[2] = '{0, 0};
    int rdy_edge[2] = '{0, 0};
    int done_cnt[2] = '{0, 0};
    logic prev_sclk[2]  = '{1'b1, 1'b1};
    logic prev_sync[2]  = '{1'b1, 1'b1};
    logic prev_ready[2] = '{1'b1, 1'b1};
    logic [15:0] sh_word[2] = '{16'h0, 16'h0};
    int falls[2] = '{0, 0};

    logic [15:0] cap_w[$];
    int          cap_f[$];
    int          acc_q[$];
    logic [15:0] last1_w = 16'h0;
    int          last1_f = 0;
    int          cap1_n  = 0;
    logic [4:0]  got;

    function automatic int div_of(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    // Expected {ready, done, sync, sclk, sdin} t clocks after the accept edge.
    function automatic logic [4:0] exp_out(input int d, input bit b, input int tt,
                                           input logic [15:0] f);
        int u;
        int bn;
        if (!b) return 5'b10110;
        if (tt < d) return {4'b0001, f[15]};
        if (tt < 33 * d) begin
            u  = tt - d;
            bn = 15 - u / (2 * d);
            if ((u % (2 * d)) < d) return {4'b0000, f[bn]};
            return {4'b0001, (bn == 0) ? 1'b0 : f[bn - 1]};
        end
        if (tt == 33 * d) return 5'b01110;
        return 5'b00110;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model update on each edge, then compare and DAC-side capture 1 unit later.
    always begin
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                busy[i] = 1'b0;
            end else if (busy[i]) begin
                t[i]++;
                if (t[i] == 35 * div_of(i) - 1) busy[i] = 1'b0;
            end else if ((i == 0) ? valid4 : valid1) begin
                busy[i]    = 1'b1;
                t[i]       = 0;
                mframe[i]  = {2'b00, pd_mode, data_in};
                acc_cyc[i] = cyc;
                if (i == 0) acc_q.push_back(cyc);
            end
        end
        if (!rst) chk_en = 1'b1;
        #1;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                got = {ready[i], done[i], sync[i], sclk[i], sdin[i]};
                check((i == 0) ? "outputs_div4" : "outputs_div1", int'(got),
                      int'(exp_out(div_of(i), busy[i], t[i], mframe[i])));
                if (done[i]) begin
                    done_cyc[i] = cyc;
                    done_cnt[i]++;
                end
                if (ready[i] && !prev_ready[i]) rdy_edge[i] = cyc + 1;
                if (!sync[i] && prev_sync[i]) begin
                    sh_word[i] = 16'h0;
                    falls[i]   = 0;
                end
                if (!sync[i] && prev_sclk[i] && !sclk[i]) begin
                    sh_word[i] = {sh_word[i][14:0], sdin[i]};
                    falls[i]++;
                end
                if (sync[i] && !prev_sync[i]) begin
                    if (falls[i] == 16) check("frame_vs_model", int'(sh_word[i]), int'(mframe[i]));
                    if (i == 0) begin
                        cap_w.push_back(sh_word[i]);
                        cap_f.push_back(falls[i]);
                    end else begin
                        last1_w = sh_word[i];
                        last1_f = falls[i];
                        cap1_n++;
                    end
                end
                prev_sclk[i]  = sclk[i];
                prev_sync[i]  = sync[i];
                prev_ready[i] = ready[i];
            end
        end
    end

    task automatic send4(input logic [11:0] d, input logic [1:0] p);
        data_in = d;
        pd_mode = p;
        valid4  = 1'b1;
        @(negedge clk);
        valid4  = 1'b0;
        data_in = ~d;      // later input changes must not reach the frame
        pd_mode = ~p;
    endtask

    task automatic wait_ready(input int i, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready[i] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(ready[i]), 1);
    endtask

    task automatic chk_frame(input string name, input logic [15:0] w, input int f);
        if (cap_w.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no frame captured, expected %0h", name, w);
        end else begin
            check(name, int'(cap_w.pop_front()), int'(w));
            check({name, "_falls"}, cap_f.pop_front(), f);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc;
        rst = 1'b0; valid4 = 1'b0; valid1 = 1'b0; data_in = '0; pd_mode = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", int'(ready[0]), 1);
        check("reset_sync",  int'(sync[0]), 1);
        check("reset_sclk",  int'(sclk[0]), 1);
        check("reset_sdin_done", int'({sdin[0], done[0]}), 0);
        check("reset_ready_div1", int'(ready[1]), 1);
        rst = 1'b1;
        @(negedge clk);

        // single frame, timing of done and ready from the accept edge
        send4(12'hA5C, 2'b00);
        wait_ready(0, "a5c_ready");
        check("a5c_done_cycle",  done_cyc[0] - acc_cyc[0], 132);
        check("a5c_ready_cycle", rdy_edge[0] - acc_cyc[0], 140);
        chk_frame("a5c_frame", 16'h0A5C, 16);

        // all-ones code with power-down bits set
        send4(12'hFFF, 2'b11);
        wait_ready(0, "fff_ready");
        chk_frame("fff_frame", 16'h3FFF, 16);

        // request while busy is dropped
        dc = done_cnt[0];
        send4(12'h321, 2'b10);
        repeat (40) @(negedge clk);
        data_in = 12'hBAD; pd_mode = 2'b01; valid4 = 1'b1;
        @(negedge clk);
        valid4 = 1'b0;
        wait_ready(0, "busy_ready");
        chk_frame("busy_frame", 16'h2321, 16);
        repeat (150) @(negedge clk);
        check("busy_no_extra_frame", cap_w.size(), 0);
        check("busy_done_count", done_cnt[0] - dc, 1);

        // valid held with data changing every cycle: back-to-back frames
        acc_q.delete();
        valid4 = 1'b1;
        for (int k = 0; k < 410; k++) begin
            data_in = 12'(32'h100 + k * 32'h111);
            pd_mode = 2'(k);
            @(negedge clk);
        end
        valid4 = 1'b0;
        wait_ready(0, "b2b_ready");
        check("b2b_accepts", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            check("b2b_gap1", acc_q[1] - acc_q[0], 140);
            check("b2b_gap2", acc_q[2] - acc_q[1], 140);
        end
        chk_frame("b2b_frame0", 16'h0100, 16);
        chk_frame("b2b_frame1", 16'h064C, 16);
        chk_frame("b2b_frame2", 16'h0B98, 16);

        // reset during the low phase of bit 7 aborts without done
        dc = done_cnt[0];
        send4(12'h777, 2'b00);
        repeat (69) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_sync",  int'(sync[0]), 1);
        check("abort_sclk",  int'(sclk[0]), 1);
        check("abort_ready", int'(ready[0]), 1);
        check("abort_no_done", done_cnt[0] - dc, 0);
        rst = 1'b1;
        chk_frame("abort_partial", 16'h000E, 9);
        send4(12'h123, 2'b01);
        wait_ready(0, "after_abort_ready");
        chk_frame("after_abort_frame", 16'h1123, 16);

        // fastest divider
        data_in = 12'h001; pd_mode = 2'b00; valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        wait_ready(1, "div1_ready");
        check("div1_done_cycle",  done_cyc[1] - acc_cyc[1], 33);
        check("div1_ready_cycle", rdy_edge[1] - acc_cyc[1], 35);
        check("div1_frame_count", cap1_n, 1);
        check("div1_frame", int'(last1_w), 16'h0001);
        check("div1_falls", last1_f, 16);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
